carry_ripple_adder_32: RTL and testbench
========================================

Name: carry_ripple_adder_32

Overview:
- WIDTH-bit ripple-carry adder with carry-in, carry-out and signed-overflow flag.
- Result is registered: one-cycle latency, with a valid strobe beside the data.
- Serves as the arithmetic core behind the byte-loading ALU controller, which loads two 32-bit operands bytewise and reads the sum back bytewise.
- The carry chain is an explicit cascade of 1-bit full-adder cells; no vendor "+" inference for the sum path.

Parameters:
- WIDTH, 32, operand/sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/cin are valid this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- sum  output  WIDTH  registered a+b+cin, low WIDTH bits
- cout  output  1  registered carry out of bit WIDTH-1
- ovf  output  1  registered signed overflow
- out_valid  output  1  sum/cout/ovf valid

Behaviour:
- Reset:
  - rst_n low forces sum=0, cout=0, ovf=0 and out_valid=0 immediately, without waiting for a clock edge.
  - Outputs hold these values while rst_n is low.
  - Release is synchronised by the user; the first capture occurs on the first rising clk with rst_n high.
- Combinational chain:
  - c[0]=cin.
  - For i=0..WIDTH-1: s[i]=a[i]^b[i]^c[i] and c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - Carry out = c[WIDTH]; overflow = c[WIDTH]^c[WIDTH-1].
- Register stage:
  - On each rising clk with rst_n high, out_valid <= in_valid.
  - If in_valid=1: sum <= s, cout <= c[WIDTH], ovf <= overflow.
  - If in_valid=0: sum/cout/ovf hold their previous values; only out_valid drops.
- Latency: exactly 1 cycle, in_valid to out_valid.
- Throughput: one operation per cycle; back-to-back in_valid is supported with no bubbles.
- No backpressure: the consumer must sample on the out_valid cycle.
- Arithmetic rules:
  - Modulo 2^WIDTH wrap-around; cout is the unsigned carry.
  - Wrap examples: all-ones + 0 + cin=1 gives sum=0 and cout=1; a=0, b=0, cin=1 gives sum=1.
- ovf is meaningful only for signed interpretation and is always computed; the consumer ignores it for unsigned use.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid=0. After release, no stale value is reported valid.
- X-handling: a, b and cin are don't-care when in_valid=0. The RTL must not propagate them into the held outputs.
- Timing: the critical path is WIDTH full-adder carry stages. No carry-lookahead is required or permitted in this block.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH=32 constant.
  - word_t typedef (logic [ALU_WIDTH-1:0]).
  - Used by this block and by the byte-loading controller.
- One sub-module, full_adder (a, b, ci -> s, co, purely combinational), instantiated WIDTH times in a generate loop.
- The register stage and flag logic live in carry_ripple_adder_32.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=5, b=7 across clock edges -> sum=0, cout=0, ovf=0, out_valid=0. Assert rst_n=0 mid-cycle -> outputs clear without a clock edge.
- Basic add: a=0x0000_0005, b=0x0000_0007, cin=0, in_valid=1 -> next cycle sum=0x0000_000C, cout=0, ovf=0, out_valid=1.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0. Also a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> same result.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1. Also a=0x8000_0000, b=0x8000_0000 -> sum=0, cout=1, ovf=1.
- Streaming and hold:
  - Back-to-back in_valid: (1+2, 0x1234_5678+0x1111_1111) -> sums 3 then 0x2345_6789 on consecutive cycles.
  - Then in_valid=0 with a/b toggling -> out_valid=0, sum holds 0x2345_6789.
- Random: 10k random a/b/cin with random in_valid, checked against a behavioural {cout,sum}=a+b+cin and the ovf formula, with one-cycle delay. Repeat at WIDTH=8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ripple adder and the byte-loading ALU controller.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef logic [ALU_WIDTH-1:0] word_t;

   // Two's-complement overflow: the carry into the sign bit differs from the carry out of it.
   function automatic logic overflow_flag(input logic carry_into_msb, input logic carry_out_msb);
      return carry_into_msb ^ carry_out_msb;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the adder's carry chain is a cascade of these.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic halfSum;

   // Sum and carry of a single bit position, kept as explicit gates so the chain stays a true ripple.
   always_comb begin
      halfSum = a ^ b;
      s       = halfSum ^ ci;
      co      = (a & b) | (ci & halfSum);
   end

endmodule

// File: rtl/carry_ripple_adder_32.sv
// WIDTH-bit ripple-carry adder with carry-in, carry-out and signed overflow, one registered stage.
module carry_ripple_adder_32
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] rawSum;
   logic             rawOvf;

   logic [WIDTH-1:0] sum_d,   sum_q;
   logic             cout_d,  cout_q;
   logic             ovf_d,   ovf_q;
   logic             valid_q;

   assign carry[0] = cin;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_chain
         full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (rawSum[i]),
            .co (carry[i+1])
         );
      end
   endgenerate

   assign rawOvf = overflow_flag(carry[WIDTH-1], carry[WIDTH]);

   // Capture a new result only when the operands are valid; otherwise hold, so idle-cycle garbage never reaches the outputs.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      if (in_valid) begin
         sum_d  = rawSum;
         cout_d = carry[WIDTH];
         ovf_d  = rawOvf;
      end
   end

   // Result register; reset clears everything immediately and discards any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         valid_q <= in_valid;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_ripple_adder_32.sv
// Self-checking bench for carry_ripple_adder_32 at WIDTH=32 and WIDTH=8.
module tb_carry_ripple_adder_32;
   import alu_pkg::*;

   localparam int W8 = 8;

   logic clk = 1'b0;
   logic rst_n;

   logic        in_valid, cin, cout, ovf, out_valid;
   word_t       a, b, sum;

   logic        v8, cin8, cout8, ovf8, outValid8;
   logic [W8-1:0] a8, b8, sum8;

   always #5 clk = ~clk;

   carry_ripple_adder_32 #(.WIDTH(ALU_WIDTH)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .ovf(ovf), .out_valid(out_valid)
   );

   carry_ripple_adder_32 #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
      .sum(sum8), .cout(cout8), .ovf(ovf8), .out_valid(outValid8)
   );

   typedef struct {
      logic        valid;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   typedef struct {
      word_t a;
      word_t b;
      logic  cin;
      word_t esum;
      logic  ecout;
      logic  eovf;
   } vec_t;

   exp_t q32[$];
   exp_t q8[$];
   int total = 0;
   int bad   = 0;

   logic [63:0] held32Sum, held8Sum;
   logic        held32Cout, held32Ovf, held8Cout, held8Ovf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected result for the 32-bit DUT: outputs update on valid, hold otherwise.
   task automatic pushExp32(input logic v, input logic [63:0] s, input logic co, input logic ov);
      exp_t e;
      if (v) begin
         held32Sum = s; held32Cout = co; held32Ovf = ov;
      end
      e.valid = v; e.sum = held32Sum; e.cout = held32Cout; e.ovf = held32Ovf;
      q32.push_back(e);
   endtask

   task automatic pushExp8(input logic v, input logic [63:0] s, input logic co, input logic ov);
      exp_t e;
      if (v) begin
         held8Sum = s; held8Cout = co; held8Ovf = ov;
      end
      e.valid = v; e.sum = held8Sum; e.cout = held8Cout; e.ovf = held8Ovf;
      q8.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (q32.size() > 0) begin
         e = q32.pop_front();
         check("valid32", {63'd0, out_valid}, {63'd0, e.valid});
         check("sum32",   {32'd0, sum},       e.sum);
         check("cout32",  {63'd0, cout},      {63'd0, e.cout});
         check("ovf32",   {63'd0, ovf},       {63'd0, e.ovf});
      end
      if (q8.size() > 0) begin
         e = q8.pop_front();
         check("valid8", {63'd0, outValid8}, {63'd0, e.valid});
         check("sum8",   {56'd0, sum8},      e.sum);
         check("cout8",  {63'd0, cout8},     {63'd0, e.cout});
         check("ovf8",   {63'd0, ovf8},      {63'd0, e.ovf});
      end
   endtask

   // One cycle: compare what the previous drive produced, then drive the new 32-bit inputs.
   task automatic applyStimulus(input logic v, input word_t aa, input word_t bb, input logic c);
      @(negedge clk);
      checkOutput();
      in_valid = v; a = aa; b = bb; cin = c;
   endtask

   task automatic clearModel();
      q32.delete(); q8.delete();
      held32Sum = '0; held32Cout = 1'b0; held32Ovf = 1'b0;
      held8Sum  = '0; held8Cout  = 1'b0; held8Ovf  = 1'b0;
   endtask

   task automatic checkZero(input string tag);
      check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_sum"},   {32'd0, sum},       64'd0);
      check({tag, "_cout"},  {63'd0, cout},      64'd0);
      check({tag, "_ovf"},   {63'd0, ovf},       64'd0);
   endtask

   vec_t vecs[6];

   initial begin
      logic [32:0] full;
      logic [8:0]  full8;
      logic        v;

      vecs[0] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};

      clearModel();
      rst_n = 1'b0;
      in_valid = 1'b1; a = 32'd5; b = 32'd7; cin = 1'b0;
      v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

      // Reset held across edges with valid operands present
      repeat (3) @(posedge clk);
      #1 checkZero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;

      // Table-driven directed vectors
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
         pushExp32(1'b1, {32'd0, vecs[i].esum}, vecs[i].ecout, vecs[i].eovf);
      end

      // Back-to-back streaming, then idle with toggling operands
      applyStimulus(1'b1, 32'd1, 32'd2, 1'b0);
      pushExp32(1'b1, 64'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
      pushExp32(1'b1, 64'h2345_6789, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, $urandom, $urandom, 1'(i));
         pushExp32(1'b0, 64'd0, 1'b0, 1'b0);
      end

      // Mid-cycle reset with a result already visible and another in flight
      applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      pushExp32(1'b1, 64'hFFFF_FFFF, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
      #2 rst_n = 1'b0;
      #1 checkZero("rst_async");
      in_valid = 1'b0;
      clearModel();
      @(negedge clk);
      checkZero("rst_edge");
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, $urandom, $urandom, 1'b1);
         pushExp32(1'b0, 64'd0, 1'b0, 1'b0);
      end

      // Random traffic on both widths, checked against a behavioural model
      for (int n = 0; n < 10000; n++) begin
         v = ($urandom_range(0, 3) != 0);
         applyStimulus(v, $urandom, $urandom, 1'($urandom_range(0, 1)));
         full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
         pushExp32(v, {32'd0, full[31:0]}, full[32], (a[31] == b[31]) && (full[31] != a[31]));

         v8 = ($urandom_range(0, 3) != 0);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
         full8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
         pushExp8(v8, {56'd0, full8[7:0]}, full8[8], (a8[7] == b8[7]) && (full8[7] != a8[7]));
      end

      @(negedge clk);
      checkOutput();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
